// File: rtl/bsg_manycore_remote_req_sched.sv
// bsg_manycore_remote_req_sched: round-robin remote-request scheduler with credit accounting and fence/drain.
// Optional stall counter enabled by BSG_MANYCORE_REMOTE_REQ_SCHED_PERF_EN.
module bsg_manycore_remote_req_sched #(
    parameter int num_req_p     = 2,
    parameter int req_width_p   = 64,
    parameter int max_credits_p = 32,
    localparam int lg_credits_lp = $clog2(max_credits_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*req_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic [req_width_p-1:0]           remote_req_o,
    output logic                             remote_req_v_o,
    input  logic                             tx_ready_i,
    input  logic                             credit_return_i,
    input  logic                             fence_i,
    output logic                             fence_done_o,
    output logic [lg_credits_lp-1:0]         credits_avail_o,
    output logic [31:0]                      perf_stall_o
);
    localparam int ptr_w_lp = $clog2(num_req_p);

    if (num_req_p < 2) begin : g_bad_num_req
        $error("num_req_p must be at least 2");
    end

    typedef enum logic [1:0] {ARB, FENCE, DONE} state_e;

    state_e                   state_q, state_d;
    logic [ptr_w_lp-1:0]      last_q, last_d, win, idx;
    logic [lg_credits_lp-1:0] credits_q, credits_d;
    logic [req_width_p-1:0]   data_q, data_d;
    logic                     v_q, v_d, done_q, done_d, grant, full;

    // Scan downward so the lowest offset from last_q+1 is the final winner.
    always_comb begin
        win = last_q;
        idx = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = ptr_w_lp'((int'(last_q) + 1 + k) % num_req_p);
            if (req_v_i[idx]) win = idx;
        end
    end

    assign full  = credits_q == lg_credits_lp'(max_credits_p);
    assign grant = (state_q == ARB) & (~v_q | tx_ready_i) & (credits_q != '0) & (|req_v_i) & ~fence_i;
    assign req_yumi_o = {{(num_req_p-1){1'b0}}, grant} << win;

    always_comb begin
        credits_d = (grant & ~credit_return_i) ? credits_q - 1'b1
                  : (~grant & credit_return_i & ~full) ? credits_q + 1'b1
                  : credits_q;
        state_d = (state_q == ARB) ? (fence_i ? FENCE : ARB)
                : (state_q == FENCE) ? ((~v_q & full) ? DONE : FENCE)
                : ARB;
        data_d = grant ? req_data_i[win*req_width_p +: req_width_p] : data_q;
        v_d    = grant | (v_q & ~tx_ready_i);
        last_d = grant ? win : last_q;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ARB;
            last_q    <= '0;
            credits_q <= lg_credits_lp'(max_credits_p);
            data_q    <= '0;
            v_q       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            credits_q <= credits_d;
            data_q    <= data_d;
            v_q       <= v_d;
            done_q    <= done_d;
        end
    end

    assign remote_req_o    = data_q;
    assign remote_req_v_o  = v_q;
    assign fence_done_o    = done_q;
    assign credits_avail_o = credits_q;

`ifdef BSG_MANYCORE_REMOTE_REQ_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;
    assign stall_d = ((|req_v_i) & (credits_q == '0) & (state_q == ARB) & ~(&stall_q)) ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) stall_q <= '0;
        else stall_q <= stall_d;
    end
    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = '0;
`endif

    // A return with a full pool means the endpoint returned a credit it never lent.
    assert property (@(posedge clk_i) disable iff (reset_i) !(credit_return_i && full))
        else $error("credit return with full credit pool");
endmodule

// File: tb/tb_bsg_manycore_remote_req_sched.sv
// tb_bsg_manycore_remote_req_sched: directed checks of arbitration, credits, tx backpressure, fence and perf counter.
module tb_bsg_manycore_remote_req_sched;
    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [1:0]   req_v_i = '0;
    logic [127:0] req_data_i = '0;
    logic         tx_ready_i = 1'b0;
    logic         credit_return_i = 1'b0;
    logic         fence_i = 1'b0;

    logic [1:0]  yumi32, yumi4;
    logic [63:0] rr32, rr4;
    logic        v32, v4, done32, done4;
    logic [5:0]  cr32;
    logic [2:0]  cr4;
    logic [31:0] perf32, perf4;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef BSG_MANYCORE_REMOTE_REQ_SCHED_PERF_EN
    localparam int perf_exp = 10;
`else
    localparam int perf_exp = 0;
`endif

    always #5 clk = ~clk;

    bsg_manycore_remote_req_sched u32 (
        .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_data_i(req_data_i),
        .req_yumi_o(yumi32), .remote_req_o(rr32), .remote_req_v_o(v32), .tx_ready_i(tx_ready_i),
        .credit_return_i(credit_return_i), .fence_i(fence_i), .fence_done_o(done32),
        .credits_avail_o(cr32), .perf_stall_o(perf32)
    );

    bsg_manycore_remote_req_sched #(.max_credits_p(4)) u4 (
        .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_data_i(req_data_i),
        .req_yumi_o(yumi4), .remote_req_o(rr4), .remote_req_v_o(v4), .tx_ready_i(tx_ready_i),
        .credit_return_i(credit_return_i), .fence_i(fence_i), .fence_done_o(done4),
        .credits_avail_o(cr4), .perf_stall_o(perf4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset_i = 1'b1; req_v_i = '0; tx_ready_i = 1'b0; credit_return_i = 1'b0; fence_i = 1'b0;
        tick; tick;
        reset_i = 1'b0;
    endtask

    initial begin
        do_reset;
        #1;
        chk("rst_v4", 64'(v4), 64'd0);
        chk("rst_data4", rr4, 64'd0);
        chk("rst_done4", 64'(done4), 64'd0);
        chk("rst_cr4", 64'(cr4), 64'd4);
        chk("rst_cr32", 64'(cr32), 64'd32);
        chk("rst_yumi4", 64'(yumi4), 64'd0);
        chk("rst_perf4", perf4, 64'd0);

        // single request from req0
        tick;
        req_v_i = 2'b01; req_data_i[63:0] = 64'hA; tx_ready_i = 1'b1;
        #1;
        chk("t1_yumi32", 64'(yumi32), 64'd1);
        chk("t1_yumi4", 64'(yumi4), 64'd1);
        chk("t1_v_before", 64'(v32), 64'd0);
        tick;
        req_v_i = 2'b00;
        #1;
        chk("t1_v32", 64'(v32), 64'd1);
        chk("t1_data32", rr32, 64'hA);
        chk("t1_cr32", 64'(cr32), 64'd31);
        chk("t1_cr4", 64'(cr4), 64'd3);
        tick;
        chk("t1_v_clear", 64'(v32), 64'd0);
        credit_return_i = 1'b1;
        tick;
        credit_return_i = 1'b0;
        #1;
        chk("t1_cr32_ret", 64'(cr32), 64'd32);
        chk("t1_cr4_ret", 64'(cr4), 64'd4);

        // both requesters held: alternation, then credit exhaustion on the 4-credit instance
        req_v_i = 2'b11; req_data_i = {64'hB1, 64'hB0};
        #1;
        chk("rr_g0", 64'(yumi4), 64'd2);
        tick;
        chk("rr_d0", rr4, 64'hB1);
        chk("rr_g1", 64'(yumi4), 64'd1);
        tick;
        chk("rr_d1", rr4, 64'hB0);
        chk("rr_v1", 64'(v4), 64'd1);
        chk("rr_g2", 64'(yumi4), 64'd2);
        tick;
        chk("rr_d2", rr4, 64'hB1);
        chk("rr_g3", 64'(yumi4), 64'd1);
        tick;
        chk("rr_d3", rr4, 64'hB0);
        chk("cr_zero", 64'(cr4), 64'd0);
        chk("cr_stall_a", 64'(yumi4), 64'd0);
        tick;
        chk("cr_v_drained", 64'(v4), 64'd0);
        chk("cr_stall_b", 64'(yumi4), 64'd0);
        credit_return_i = 1'b1;
        #1;
        chk("cr_stall_ret", 64'(yumi4), 64'd0);
        tick;
        credit_return_i = 1'b0;
        #1;
        chk("cr_one", 64'(cr4), 64'd1);
        chk("cr_regrant", 64'(yumi4), 64'd2);
        tick;
        chk("cr_after", 64'(yumi4), 64'd0);
        chk("cr_zero2", 64'(cr4), 64'd0);
        chk("cr_data", rr4, 64'hB1);

        // tx backpressure
        do_reset;
        req_v_i = 2'b01; req_data_i[63:0] = 64'hC; tx_ready_i = 1'b1;
        #1;
        chk("bp_g0", 64'(yumi4), 64'd1);
        tick;
        tx_ready_i = 1'b0; req_v_i = 2'b11; req_data_i[127:64] = 64'hD;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_yumi", 64'(yumi4), 64'd0);
            chk("bp_hold_data", rr4, 64'hC);
            chk("bp_hold_v", 64'(v4), 64'd1);
            tick;
        end
        tx_ready_i = 1'b1;
        #1;
        chk("bp_release", 64'(yumi4), 64'd2);
        tick;
        req_v_i = 2'b00;
        #1;
        chk("bp_data", rr4, 64'hD);
        chk("bp_cr", 64'(cr4), 64'd2);
        tick;

        // fence with three outstanding
        req_v_i = 2'b01; req_data_i[63:0] = 64'hE;
        #1;
        chk("fn_pre_g", 64'(yumi4), 64'd1);
        tick;
        fence_i = 1'b1;
        #1;
        chk("fn_cr", 64'(cr4), 64'd1);
        chk("fn_block0", 64'(yumi4), 64'd0);
        tick;
        chk("fn_block1", 64'(yumi4), 64'd0);
        for (int i = 0; i < 3; i++) begin
            credit_return_i = 1'b1;
            #1;
            chk("fn_ret_yumi", 64'(yumi4), 64'd0);
            chk("fn_ret_done", 64'(done4), 64'd0);
            tick;
        end
        credit_return_i = 1'b0;
        #1;
        chk("fn_cr_full", 64'(cr4), 64'd4);
        chk("fn_not_yet", 64'(done4), 64'd0);
        tick;
        chk("fn_done", 64'(done4), 64'd1);
        chk("fn_done_yumi", 64'(yumi4), 64'd0);
        fence_i = 1'b0;
        tick;
        chk("fn_done_pulse", 64'(done4), 64'd0);
        chk("fn_resume", 64'(yumi4), 64'd1);
        tick;
        req_v_i = 2'b00;

        // fence with nothing outstanding
        do_reset;
        fence_i = 1'b1;
        tick;
        chk("fe_c1", 64'(done4), 64'd0);
        tick;
        chk("fe_c2", 64'(done4), 64'd1);
        fence_i = 1'b0;
        tick;
        chk("fe_c3", 64'(done4), 64'd0);

        // stall counter
        do_reset;
        req_v_i = 2'b01; tx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        chk("pf_cr0", 64'(cr4), 64'd0);
        for (int i = 0; i < 10; i++) tick;
        req_v_i = 2'b00;
        chk("pf_stall4", perf4, 64'(perf_exp));
        chk("pf_stall32", perf32, 64'd0);

        // reset mid-operation discards outstanding credits
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        chk("mr_cr", 64'(cr4), 64'd4);
        chk("mr_v", 64'(v4), 64'd0);
        chk("mr_perf", perf4, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
